// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO ahead of a uart with no busy flag: buffers host bursts and
// strobes one byte per frame slot, pacing the uart with a frame-gap counter.
module uart_tx_fifo #(
    parameter int AW           = 4,
    parameter int FRAME_CYCLES = 1040
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          write,
    output logic [7:0]    data
);
    localparam int DEPTH = 2 ** AW;
    localparam int GW    = $clog2(FRAME_CYCLES + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(FRAME_CYCLES);

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap, gap_next;
    state_t        state, state_next;
    logic          write_next;
    logic [7:0]    data_next;
    logic          push, pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = wr_en && !full && !flush;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        gap_next   = gap;
        write_next = 1'b0;
        data_next  = data;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    data_next  = mem[rd_ptr];
                    state_next = STROBE;
                end
            end
            STROBE: begin
                write_next = 1'b1;
                gap_next   = GAP_LOAD;
                state_next = GAP;
            end
            GAP: begin
                gap_next = gap - GW'(1);
                if (gap == GW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            gap_next   = '0;
            write_next = 1'b0;
            data_next  = 8'h00;
            pop        = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            gap      <= '0;
            write    <= 1'b0;
            data     <= 8'h00;
        end else begin
            overflow <= wr_en && full && !flush;
            state    <= state_next;
            gap      <= gap_next;
            write    <= write_next;
            data     <= data_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + (AW + 1)'(1);
                else if (pop && !push) count <= count - (AW + 1)'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; empty/count guard every read of stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule
